// File: rtl/vga_pixfetch.sv
// vga_pixfetch: fetches framebuffer words over a req/ack port into a small word FIFO
// and streams them out as RGB332 pixels aligned with the 1-cycle-delayed sync strobes.
module vga_pixfetch #(
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_visible,
    input  logic              i_hSync,
    input  logic              i_vSync,
    input  logic              i_inth,
    input  logic              i_intv,
    input  logic [ADDR_W-1:0] i_fbBase,
    input  logic [ADDR_W-1:0] i_fbWords,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_data,
    output logic              o_visible,
    output logic              o_hSync,
    output logic              o_vSync,
    output logic [7:0]        o_rgb,
    output logic              o_underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;

    fetch_state_t      state_q, state_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              phase_q, phase_d;
    logic [7:0]        rgb_q, rgb_d;
    logic              underflow_q, underflow_d;
    logic              visible_q, hsync_q, vsync_q;
    logic [15:0]       fifo_q [DEPTH];

    logic              frame_start;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [15:0]       head_word;

    assign frame_start = i_inth & i_intv;
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    assign head_word   = fifo_q[rd_ptr_q];

    // Fetch FSM: a request issued before a frame start is finished in DRAIN and its data dropped.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!frame_start && armed_q && (remaining_q != '0) && !fifo_full) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!frame_start) begin
                        push        = 1'b1;
                        addr_d      = addr_q + ADDR_W'(1);
                        remaining_d = remaining_q - ADDR_W'(1);
                        if (remaining_q == ADDR_W'(1)) begin
                            armed_d = 1'b0;
                        end
                    end
                end else if (frame_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        if (frame_start) begin
            addr_d      = i_fbBase;
            remaining_d = i_fbWords;
            armed_d     = 1'b1;
        end
    end

    always_comb begin
        pop         = 1'b0;
        rgb_d       = 8'h00;
        phase_d     = phase_q;
        underflow_d = underflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (i_visible) begin
            if (fifo_empty) begin
                underflow_d = 1'b1;
            end else begin
                rgb_d   = phase_q ? head_word[15:8] : head_word[7:0];
                phase_d = ~phase_q;
                pop     = phase_q;
            end
        end
        if (frame_start) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            phase_d     = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            phase_q     <= 1'b0;
            rgb_q       <= 8'h00;
            underflow_q <= 1'b0;
            visible_q   <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
            visible_q   <= i_visible;
            hsync_q     <= i_hSync;
            vsync_q     <= i_vSync;
        end
    end

    // Word storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= i_mem_data;
        end
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_visible   = visible_q;
    assign o_hSync     = hsync_q;
    assign o_vSync     = vsync_q;
    assign o_rgb       = rgb_q;
    assign o_underflow = underflow_q;
endmodule

// File: tb/tb_vga_pixfetch.sv
// tb_vga_pixfetch: randomized bench; a scripted memory responder plus a byte-queue
// model of the pixel stream supply every expected value.
`timescale 1ns/1ps
module tb_vga_pixfetch;
    localparam int ADDR_W = 18;
    localparam int DEPTH  = 8;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_visible = 1'b0;
    logic              i_hSync = 1'b0;
    logic              i_vSync = 1'b0;
    logic              i_inth = 1'b0;
    logic              i_intv = 1'b0;
    logic [ADDR_W-1:0] i_fbBase = '0;
    logic [ADDR_W-1:0] i_fbWords = '0;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack = 1'b0;
    logic [15:0]       i_mem_data = 16'h0000;
    logic              o_visible;
    logic              o_hSync;
    logic              o_vSync;
    logic [7:0]        o_rgb;
    logic              o_underflow;

    int checks = 0;
    int passes = 0;
    int seed = 0;
    int ack_delay = 0;
    int ack_cnt = 0;
    int frame_id = 0;
    int addr_moved_cnt = 0;
    logic [ADDR_W-1:0] req_log[$];
    logic [15:0] mem_img [int];

    bit pend = 1'b0;
    int wait_left = 0;
    int pend_tag = 0;
    int ack_tag = 0;
    logic [ADDR_W-1:0] pend_addr = '0;

    logic [7:0] pix_q[$];
    logic [7:0] exp_rgb = 8'h00;
    logic exp_uf = 1'b0;
    logic exp_vis = 1'b0;
    logic exp_hs = 1'b0;
    logic exp_vs = 1'b0;
    int frame_base = 0;
    int frame_idx = 0;

    always #5 clk = ~clk;

    vga_pixfetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_visible(i_visible), .i_hSync(i_hSync),
        .i_vSync(i_vSync), .i_inth(i_inth), .i_intv(i_intv), .i_fbBase(i_fbBase),
        .i_fbWords(i_fbWords), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .o_visible(o_visible),
        .o_hSync(o_hSync), .o_vSync(o_vSync), .o_rgb(o_rgb), .o_underflow(o_underflow)
    );

    function automatic logic [15:0] word_of(input int a);
        if (mem_img.exists(a)) return mem_img[a];
        return 16'((a * 40503) ^ seed);
    endfunction

    // Memory responder: acks each request ack_delay cycles after it appears, tagged with its frame.
    always @(negedge clk) begin
        i_mem_ack = 1'b0;
        if (o_mem_req !== 1'b1) begin
            pend = 1'b0;
        end else begin
            if (!pend) begin
                pend = 1'b1;
                wait_left = ack_delay;
                pend_addr = o_mem_addr;
                pend_tag = frame_id;
                req_log.push_back(o_mem_addr);
            end else if (o_mem_addr !== pend_addr) begin
                addr_moved_cnt++;
            end
            if (wait_left == 0) begin
                i_mem_ack = 1'b1;
                i_mem_data = word_of(int'(pend_addr));
                ack_tag = pend_tag;
                ack_cnt++;
                pend = 1'b0;
            end else begin
                wait_left--;
            end
        end
    end

    // One clock of stimulus; afterwards the inputs are scrambled so only registered outputs match.
    task automatic drive_cycle(input logic vis, input logic hs, input logic vs, input logic fs);
        logic [15:0] w;
        i_visible = vis;
        i_hSync = hs;
        i_vSync = vs;
        i_inth = fs;
        i_intv = fs;
        @(posedge clk);
        #1;
        exp_vis = vis;
        exp_hs = hs;
        exp_vs = vs;
        exp_rgb = 8'h00;
        if (i_reset) begin
            pix_q.delete();
            exp_uf = 1'b0;
            exp_vis = 1'b0;
            exp_hs = 1'b0;
            exp_vs = 1'b0;
            frame_id++;
            frame_idx = 0;
        end else begin
            if (vis) begin
                if (pix_q.size() > 0) exp_rgb = pix_q.pop_front();
                else exp_uf = 1'b1;
            end
            if (fs) begin
                pix_q.delete();
                exp_uf = 1'b0;
                frame_id++;
                frame_base = int'(i_fbBase);
                frame_idx = 0;
            end
            if (i_mem_ack && ack_tag == frame_id) begin
                w = word_of((frame_base + frame_idx) & AMASK);
                pix_q.push_back(w[7:0]);
                pix_q.push_back(w[15:8]);
                frame_idx++;
            end
        end
        i_visible = ~vis;
        i_hSync = ~hs;
        i_vSync = ~vs;
        i_inth = 1'b0;
        i_intv = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_fbWords = ADDR_W'(5);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({o_visible, o_hSync, o_vSync, o_underflow, o_rgb} !== 12'h000)
            $display("[TB] FAIL reset_outputs: got %h want 000", {o_visible, o_hSync, o_vSync, o_underflow, o_rgb});
        else passes++;
        checks++;
        if (o_mem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", o_mem_req);
        else passes++;
        i_reset = 1'b0;
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (req_log.size() != 0) $display("[TB] FAIL reset_disarmed: got %0d requests want 0", req_log.size());
        else passes++;
        checks++;
        if ({o_visible, o_hSync, o_vSync, o_underflow, o_rgb} !== 12'h000)
            $display("[TB] FAIL post_reset_outputs: got %h want 000", {o_visible, o_hSync, o_vSync, o_underflow, o_rgb});
        else passes++;
    endtask

    task automatic test_fetch_basic();
        mem_img[32'h100] = 16'hA1B2;
        mem_img[32'h101] = 16'hC3D4;
        ack_delay = 2;
        req_log.delete();
        i_fbBase = ADDR_W'(32'h100);
        i_fbWords = ADDR_W'(4);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (req_log.size() != 4) $display("[TB] FAIL basic_req_count: got %0d want 4", req_log.size());
        else passes++;
        for (int i = 0; i < req_log.size() && i < 4; i++) begin
            checks++;
            if (req_log[i] !== ADDR_W'(32'h100 + i))
                $display("[TB] FAIL basic_addr: req %0d got %h want %h", i, req_log[i], 32'h100 + i);
            else passes++;
        end
        checks++;
        if (o_mem_req !== 1'b0) $display("[TB] FAIL basic_req_idle: got %b want 0", o_mem_req);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_visible, o_hSync, o_vSync, o_underflow, o_rgb} !== {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb})
                $display("[TB] FAIL basic_pixel: cycle %0d got %h want %h", i,
                         {o_visible, o_hSync, o_vSync, o_underflow, o_rgb}, {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb});
            else passes++;
        end
    endtask

    task automatic test_fifo_full();
        int pre;
        int base;
        ack_delay = 0;
        req_log.delete();
        pre = ack_cnt;
        base = 32'h1000 + int'($urandom_range(0, 255));
        i_fbBase = ADDR_W'(base);
        i_fbWords = ADDR_W'(20);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ack_cnt - pre != DEPTH) $display("[TB] FAIL full_acks: got %0d want %0d", ack_cnt - pre, DEPTH);
        else passes++;
        checks++;
        if (o_mem_req !== 1'b0) $display("[TB] FAIL full_req_low: got %b want 0", o_mem_req);
        else passes++;
        for (int n = 1; n <= 3; n++) begin
            for (int i = 0; i < 2; i++) begin
                drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
                checks++;
                if (o_rgb !== exp_rgb) $display("[TB] FAIL full_pop_rgb: got %h want %h", o_rgb, exp_rgb);
                else passes++;
            end
            for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (ack_cnt - pre != DEPTH + n)
                $display("[TB] FAIL full_refill: got %0d acks want %0d", ack_cnt - pre, DEPTH + n);
            else passes++;
        end
        for (int i = 0; i < 35; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_underflow, o_rgb} !== {exp_uf, exp_rgb})
                $display("[TB] FAIL full_drain: cycle %0d got %h want %h", i, {o_underflow, o_rgb}, {exp_uf, exp_rgb});
            else passes++;
        end
        checks++;
        if (req_log.size() != 20) $display("[TB] FAIL full_total_reqs: got %0d want 20", req_log.size());
        else passes++;
        for (int i = 0; i < req_log.size() && i < 20; i++) begin
            checks++;
            if (req_log[i] !== ADDR_W'(base + i))
                $display("[TB] FAIL full_addr: req %0d got %h want %h", i, req_log[i], base + i);
            else passes++;
        end
    endtask

    task automatic test_fs_during_req();
        int n;
        ack_delay = 5;
        req_log.delete();
        i_fbBase = ADDR_W'(32'h105);
        i_fbWords = ADDR_W'(3);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (o_mem_req !== 1'b1 && n < 20) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== ADDR_W'(32'h105))
            $display("[TB] FAIL fs_first_req: req %b addr %h want req 1 addr 105", o_mem_req, o_mem_addr);
        else passes++;
        i_fbBase = ADDR_W'(32'h200);
        i_fbWords = ADDR_W'(2);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== ADDR_W'(32'h105) || o_underflow !== 1'b0)
            $display("[TB] FAIL fs_drain_hold: req %b addr %h uf %b want 1 105 0", o_mem_req, o_mem_addr, o_underflow);
        else passes++;
        for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (req_log.size() != 3) $display("[TB] FAIL fs_req_count: got %0d want 3", req_log.size());
        else passes++;
        if (req_log.size() == 3) begin
            checks++;
            if (req_log[1] !== ADDR_W'(32'h200) || req_log[2] !== ADDR_W'(32'h201))
                $display("[TB] FAIL fs_new_addr: got %h %h want 200 201", req_log[1], req_log[2]);
            else passes++;
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_underflow, o_rgb} !== {exp_uf, exp_rgb})
                $display("[TB] FAIL fs_pixel: cycle %0d got %h want %h", i, {o_underflow, o_rgb}, {exp_uf, exp_rgb});
            else passes++;
        end
    endtask

    task automatic test_underflow();
        bit req_seen;
        ack_delay = 1;
        i_fbBase = ADDR_W'(32'h300);
        i_fbWords = ADDR_W'(1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i < 4, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_underflow, o_rgb} !== {exp_uf, exp_rgb})
                $display("[TB] FAIL underflow_seq: cycle %0d got %h want %h", i, {o_underflow, o_rgb}, {exp_uf, exp_rgb});
            else passes++;
        end
        i_fbWords = '0;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_underflow !== 1'b0) $display("[TB] FAIL underflow_clear: got %b want 0", o_underflow);
        else passes++;
        req_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (o_mem_req === 1'b1) req_seen = 1'b1;
        end
        checks++;
        if (req_seen) $display("[TB] FAIL zero_words: got req 1 want no request");
        else passes++;
    endtask

    task automatic test_wrap();
        ack_delay = int'($urandom_range(0, 3));
        req_log.delete();
        i_fbBase = ADDR_W'(32'h3FFFE);
        i_fbWords = ADDR_W'(4);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (req_log.size() != 4) $display("[TB] FAIL wrap_count: got %0d want 4", req_log.size());
        else passes++;
        for (int i = 0; i < req_log.size() && i < 4; i++) begin
            checks++;
            if (req_log[i] !== ADDR_W'(32'h3FFFE + i))
                $display("[TB] FAIL wrap_addr: req %0d got %h want %h", i, req_log[i], ADDR_W'(32'h3FFFE + i));
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (o_rgb !== exp_rgb) $display("[TB] FAIL wrap_pixel: cycle %0d got %h want %h", i, o_rgb, exp_rgb);
            else passes++;
        end
    endtask

    task automatic test_sync_delay();
        int hs_first;
        int hs_count;
        logic hs;
        hs_first = -1;
        hs_count = 0;
        for (int i = 0; i < 110; i++) begin
            hs = (i >= 5 && i < 101);
            drive_cycle(1'($urandom_range(0, 1)), hs, 1'($urandom_range(0, 1)), 1'b0);
            if (o_hSync === 1'b1) begin
                hs_count++;
                if (hs_first < 0) hs_first = i;
            end
            checks++;
            if ({o_visible, o_hSync, o_vSync, o_underflow, o_rgb} !== {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb})
                $display("[TB] FAIL sync_delay: cycle %0d got %h want %h", i,
                         {o_visible, o_hSync, o_vSync, o_underflow, o_rgb}, {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb});
            else passes++;
        end
        checks++;
        if (hs_count != 96 || hs_first != 5)
            $display("[TB] FAIL hsync_pulse: got len %0d start %0d want len 96 start 5", hs_count, hs_first);
        else passes++;
    endtask

    task automatic test_random_frames();
        int ncyc;
        for (int f = 0; f < 6; f++) begin
            ack_delay = int'($urandom_range(0, 3));
            i_fbBase = ADDR_W'($urandom);
            i_fbWords = ADDR_W'($urandom_range(1, 14));
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            ncyc = int'($urandom_range(30, 90));
            for (int i = 0; i < ncyc; i++) begin
                drive_cycle(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                checks++;
                if ({o_visible, o_hSync, o_vSync, o_underflow, o_rgb} !== {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb})
                    $display("[TB] FAIL random_frame: frame %0d cycle %0d got %h want %h", f, i,
                             {o_visible, o_hSync, o_vSync, o_underflow, o_rgb}, {exp_vis, exp_hs, exp_vs, exp_uf, exp_rgb});
                else passes++;
            end
        end
    endtask

    initial begin
        seed = int'($urandom);
        test_reset();
        test_fetch_basic();
        test_fifo_full();
        test_fs_during_req();
        test_underflow();
        test_wrap();
        test_sync_delay();
        test_random_frames();
        checks++;
        if (addr_moved_cnt != 0) $display("[TB] FAIL addr_stable: got %0d address changes want 0", addr_moved_cnt);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
